// File: rtl/mcu0_pkg.sv
// Shared definitions for the mcu0 accumulator CPU: opcodes and the fetch FSM state type.
package mcu0_pkg;

   localparam int W = 15;  // instruction MSB index

   localparam logic [3:0] OP_LD  = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_JMP = 4'h2;
   localparam logic [3:0] OP_ST  = 4'h3;
   localparam logic [3:0] OP_CMP = 4'h4;
   localparam logic [3:0] OP_JEQ = 4'h5;

   typedef enum logic [1:0] {
      F_IDLE = 2'd0,
      F_HI   = 2'd1,
      F_LO   = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/mcu0_fetch_fifo.sv
// Prefetch FIFO holding {pc, instruction} entries; head and valid are registered.
module mcu0_fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int EW    = 32,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          push,
   input  logic [EW-1:0] din,
   input  logic          pop,
   input  logic          flush,
   output logic [EW-1:0] head,
   output logic          valid,
   output logic [CW-1:0] count
);

   localparam int PW = $clog2(DEPTH);

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count_n;
   logic          pop_ok, push_ok;

   assign pop_ok  = pop && (count != '0);
   assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);

   always_comb begin
      count_n = count;
      if (flush)
         count_n = '0;
      else if (push_ok && !pop_ok)
         count_n = count + CW'(1);
      else if (pop_ok && !push_ok)
         count_n = count - CW'(1);
   end

   // The head register is refreshed from the entry behind the popped one, or
   // from the incoming word when the FIFO would otherwise be empty.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         valid  <= 1'b0;
         head   <= '0;
      end else begin
         count <= count_n;
         valid <= (count_n != '0);
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push_ok)
               wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)
               rd_ptr <= rd_ptr + PW'(1);
            if (pop_ok && (count > CW'(1)))
               head <= mem[rd_ptr + PW'(1)];
            else if (push_ok && ((count == '0) || (pop_ok && (count == CW'(1)))))
               head <= din;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok && !flush)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mcu0_fetch.sv
// mcu0 instruction fetch: two byte reads per instruction into a prefetch FIFO.
// Optional MCU0_FETCH_ALIGN_CHECK_EN forces even jump targets and adds a misalign flag.
module mcu0_fetch
   import mcu0_pkg::*;
#(
   parameter int AW    = 16,
   parameter int DEPTH = 2
) (
   input  logic          clock,
   input  logic          reset_n,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   input  logic [7:0]    mem_rdata,
   output logic          ir_valid,
   output logic [15:0]   ir,
   output logic [AW-1:0] ir_pc,
   input  logic          ir_ready,
   input  logic          jump,
   input  logic [AW-1:0] jump_addr
`ifdef MCU0_FETCH_ALIGN_CHECK_EN
   ,
   output logic          misalign
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t  state, state_n;
   logic [AW-1:0] fetch_pc, fetch_pc_n, addr_n, target;
   logic          lo_pend, lo_pend_n;
   logic [7:0]    hi_byte;
   logic [CW-1:0] count;
   logic [AW+15:0] head;
   logic          pop;

`ifdef MCU0_FETCH_ALIGN_CHECK_EN
   assign target = {jump_addr[AW-1:1], 1'b0};
`else
   assign target = jump_addr;
`endif

   assign pop = ir_valid && ir_ready;

   // Start a new instruction only when a FIFO slot is guaranteed for it.
   always_comb begin
      state_n    = state;
      fetch_pc_n = fetch_pc;
      addr_n     = mem_addr;
      lo_pend_n  = 1'b0;
      if (lo_pend)
         fetch_pc_n = fetch_pc + AW'(2);
      case (state)
         F_IDLE: begin
            if ((count + CW'(lo_pend)) < CW'(DEPTH)) begin
               state_n = F_HI;
               addr_n  = fetch_pc_n;
            end
         end
         F_HI: begin
            state_n = F_LO;
            addr_n  = mem_addr + AW'(1);
         end
         F_LO: begin
            lo_pend_n = 1'b1;
            if ((count + CW'(1)) < CW'(DEPTH)) begin
               state_n = F_HI;
               addr_n  = fetch_pc + AW'(2);
            end else begin
               state_n = F_IDLE;
            end
         end
         default: state_n = F_IDLE;
      endcase
      if (jump) begin
         state_n    = F_HI;
         fetch_pc_n = target;
         addr_n     = target;
         lo_pend_n  = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= F_IDLE;
         fetch_pc <= '0;
         lo_pend  <= 1'b0;
         mem_rd   <= 1'b0;
         mem_addr <= '0;
      end else begin
         state    <= state_n;
         fetch_pc <= fetch_pc_n;
         lo_pend  <= lo_pend_n;
         mem_rd   <= (state_n != F_IDLE);
         mem_addr <= addr_n;
      end
   end

   always_ff @(posedge clock) begin
      if (state == F_LO)
         hi_byte <= mem_rdata;
   end

`ifdef MCU0_FETCH_ALIGN_CHECK_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         misalign <= 1'b0;
      else
         misalign <= jump && jump_addr[0];
   end
`endif

   mcu0_fetch_fifo #(
      .DEPTH (DEPTH),
      .EW    (AW + 16),
      .CW    (CW)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (lo_pend),
      .din     ({fetch_pc, hi_byte, mem_rdata}),
      .pop     (pop),
      .flush   (jump),
      .head    (head),
      .valid   (ir_valid),
      .count   (count)
   );

   assign ir    = head[15:0];
   assign ir_pc = head[AW+15:16];

endmodule

// File: tb/tb_mcu0_fetch.sv
// Directed bench for mcu0_fetch: reset, streaming, backpressure, redirect, wrap and alignment.
module tb_mcu0_fetch;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rdata = 8'hEE;
   logic        ir_valid;
   logic [15:0] ir;
   logic [15:0] ir_pc;
   logic        ir_ready;
   logic        jump;
   logic [15:0] jump_addr;
`ifdef MCU0_FETCH_ALIGN_CHECK_EN
   logic        misalign;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   mcu0_fetch dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .ir_valid  (ir_valid),
      .ir        (ir),
      .ir_pc     (ir_pc),
      .ir_ready  (ir_ready),
      .jump      (jump),
      .jump_addr (jump_addr)
`ifdef MCU0_FETCH_ALIGN_CHECK_EN
      ,
      .misalign  (misalign)
`endif
   );

   // Byte at address a is {a[3:0]+1, a[7:4]}: 00:10 01:20 02:30 03:40 ...
   function automatic logic [7:0] mbyte(input logic [15:0] a);
      mbyte = {a[3:0] + 4'd1, a[7:4]};
   endfunction

   always @(posedge clock)
      mem_rdata <= mem_rd ? mbyte(mem_addr) : 8'hEE;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      ir_ready  = 1'b1;
      jump      = 1'b0;
      jump_addr = 16'h0000;

      tick(2);
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_ir_valid", 32'(ir_valid), 32'd0);
      chk("rst_ir", 32'(ir), 32'h0);
      chk("rst_ir_pc", 32'(ir_pc), 32'h0);
`ifdef MCU0_FETCH_ALIGN_CHECK_EN
      chk("rst_misalign", 32'(misalign), 32'd0);
`endif

      // streaming with ir_ready=1
      reset_n = 1'b1;
      tick(1);
      chk("c0_mem_rd", 32'(mem_rd), 32'd1);
      chk("c0_mem_addr", 32'(mem_addr), 32'h0000);
      tick(1);
      chk("c1_mem_addr", 32'(mem_addr), 32'h0001);
      tick(1);
      chk("c2_ir_valid", 32'(ir_valid), 32'd0);
      chk("c2_mem_addr", 32'(mem_addr), 32'h0002);
      tick(1);
      chk("c3_ir_valid", 32'(ir_valid), 32'd1);
      chk("c3_ir", 32'(ir), 32'h1020);
      chk("c3_ir_pc", 32'(ir_pc), 32'h0000);
      tick(1);
      chk("c4_ir_valid", 32'(ir_valid), 32'd0);
      tick(1);
      chk("c5_ir_valid", 32'(ir_valid), 32'd1);
      chk("c5_ir", 32'(ir), 32'h3040);
      chk("c5_ir_pc", 32'(ir_pc), 32'h0002);

      // reset asserted mid-operation clears outputs without a clock edge
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_mem_rd", 32'(mem_rd), 32'd0);
      chk("midrst_mem_addr", 32'(mem_addr), 32'h0);
      chk("midrst_ir_valid", 32'(ir_valid), 32'd0);
      chk("midrst_ir", 32'(ir), 32'h0);

      // backpressure: ir_ready=0 for 10 cycles from reset
      ir_ready = 1'b0;
      tick(1);
      reset_n = 1'b1;
      tick(1);
      chk("bp_c0_mem_addr", 32'(mem_addr), 32'h0000);
      for (int k = 1; k <= 9; k++) begin
         tick(1);
         if (k >= 5)
            chk($sformatf("bp_c%0d_mem_rd", k), 32'(mem_rd), 32'd0);
      end
      chk("bp_ir_valid", 32'(ir_valid), 32'd1);
      chk("bp_ir", 32'(ir), 32'h1020);
      chk("bp_ir_pc", 32'(ir_pc), 32'h0000);
      ir_ready = 1'b1;
      tick(1);
      chk("drain_ir", 32'(ir), 32'h3040);
      chk("drain_ir_pc", 32'(ir_pc), 32'h0002);
      chk("drain_ir_valid", 32'(ir_valid), 32'd1);
      tick(1);
      chk("resume_ir_valid", 32'(ir_valid), 32'd0);
      chk("resume_mem_rd", 32'(mem_rd), 32'd1);
      chk("resume_mem_addr", 32'(mem_addr), 32'h0004);
      tick(3);
      chk("pc4_ir", 32'(ir), 32'h5060);
      chk("pc4_ir_pc", 32'(ir_pc), 32'h0004);

      // jump while the low byte read is in flight
      jump      = 1'b1;
      jump_addr = 16'h0010;
      tick(1);
      jump = 1'b0;
      chk("jmp_mem_addr", 32'(mem_addr), 32'h0010);
      chk("jmp_mem_rd", 32'(mem_rd), 32'd1);
      chk("jmp_ir_valid_c1", 32'(ir_valid), 32'd0);
      tick(1);
      chk("jmp_ir_valid_c2", 32'(ir_valid), 32'd0);
      tick(1);
      chk("jmp_ir_valid_c3", 32'(ir_valid), 32'd0);
      tick(1);
      chk("jmp_ir", 32'(ir), 32'h1121);
      chk("jmp_ir_pc", 32'(ir_pc), 32'h0010);

      // fill both entries, then jump with a simultaneous pop to FFFE
      ir_ready = 1'b0;
      tick(3);
      chk("full_ir", 32'(ir), 32'h1121);
      chk("full_ir_pc", 32'(ir_pc), 32'h0010);
      chk("full_mem_rd", 32'(mem_rd), 32'd0);
      ir_ready  = 1'b1;
      jump      = 1'b1;
      jump_addr = 16'hFFFE;
      tick(1);
      jump = 1'b0;
      chk("flush_ir_valid", 32'(ir_valid), 32'd0);
      chk("wrap_addr_fffe", 32'(mem_addr), 32'hFFFE);
      tick(1);
      chk("wrap_addr_ffff", 32'(mem_addr), 32'hFFFF);
      tick(1);
      chk("wrap_addr_0000", 32'(mem_addr), 32'h0000);
      tick(1);
      chk("wrap_ir", 32'(ir), 32'hFF0F);
      chk("wrap_ir_pc", 32'(ir_pc), 32'hFFFE);
      tick(2);
      chk("wrap_next_valid", 32'(ir_valid), 32'd1);
      chk("wrap_next_ir", 32'(ir), 32'h1020);
      chk("wrap_next_ir_pc", 32'(ir_pc), 32'h0000);

      // odd jump target
      jump      = 1'b1;
      jump_addr = 16'h0013;
      tick(1);
      jump = 1'b0;
      chk("odd_ir_valid", 32'(ir_valid), 32'd0);
`ifdef MCU0_FETCH_ALIGN_CHECK_EN
      chk("odd_misalign_c1", 32'(misalign), 32'd1);
      chk("odd_mem_addr_c1", 32'(mem_addr), 32'h0012);
      tick(1);
      chk("odd_misalign_c2", 32'(misalign), 32'd0);
      chk("odd_mem_addr_c2", 32'(mem_addr), 32'h0013);
      tick(2);
      chk("odd_ir", 32'(ir), 32'h3141);
      chk("odd_ir_pc", 32'(ir_pc), 32'h0012);
`else
      chk("odd_mem_addr_c1", 32'(mem_addr), 32'h0013);
      tick(1);
      chk("odd_mem_addr_c2", 32'(mem_addr), 32'h0014);
      tick(2);
      chk("odd_ir", 32'(ir), 32'h4151);
      chk("odd_ir_pc", 32'(ir_pc), 32'h0013);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
